modinv_helper_halve: RTL and testbench

- Word-serial modular halving helper for the binary modular invertor.
- Computes y = (x + x[0]·n) >> 1: halves x exactly when x is even; otherwise adds the odd modulus n first, then halves.
- Reads the x and n buffers LSW-first and writes the y buffer LSW-first. This makes it the writer-side counterpart to the compare helper, which only reads buffers.
- Sits beside the compare helper under the invertor FSM and updates the r/s coefficient buffers.

---
 rtl/modinv_helper_halve_pkg.sv | 26 ++
 rtl/modinv_helper_halve_adder32_wrapper.sv | 32 +++
 rtl/modinv_helper_halve.sv | 128 ++++++++++++
 tb/tb_modinv_helper_halve.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/modinv_helper_halve_pkg.sv
// -----------------------------------------------------------------------------
// modinv_helper_halve_pkg
// Shared types and helpers for the word-serial modular halving helper.
//   word_t  : one 32-bit buffer word
//   clog2() : ceiling log2, used to size the sequencing counter
// -----------------------------------------------------------------------------
package modinv_helper_halve_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/modinv_helper_halve_adder32_wrapper.sv
// -----------------------------------------------------------------------------
// adder32_wrapper
// Registered 32-bit adder with carry-in and registered carry-out (latency 1).
// Ports:
//   clk   : clock, posedge
//   a, b  : 32-bit addends
//   c_in  : carry in
//   s     : registered sum
//   c_out : registered carry out
// -----------------------------------------------------------------------------
module adder32_wrapper
    import modinv_helper_halve_pkg::*;
(
    input  logic  clk,
    input  word_t a,
    input  word_t b,
    input  logic  c_in,
    output word_t s,
    output logic  c_out
);

    word_t s_q;
    logic  c_out_q;

    always_ff @(posedge clk) begin
        {c_out_q, s_q} <= {1'b0, a} + {1'b0, b} + {{WORD_BITS{1'b0}}, c_in};
    end

    assign s     = s_q;
    assign c_out = c_out_q;

endmodule

// File: rtl/modinv_helper_halve.sv
// -----------------------------------------------------------------------------
// modinv_helper_halve
// Word-serial modular halving: y = (x + x[0]*n) >> 1, LSW first.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   ena / rdy       : start request (sampled while rdy=1) / idle flag
//   x_addr, x_din   : x buffer read port (1-cycle read latency)
//   n_addr, n_din   : n buffer read port (same address as x)
//   y_addr, y_wren,
//   y_dout          : y buffer write port
// Timeline (cycle = proc_cnt value): reads issued 1..N, mask taken in 2,
// sums registered 3..N+2, writes 4..N+3, then back to idle.
// -----------------------------------------------------------------------------
module modinv_helper_halve
    import modinv_helper_halve_pkg::*;
#(
    parameter int BUFFER_NUM_WORDS = 9,
    parameter int BUFFER_ADDR_BITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    output logic                        rdy,
    output logic [BUFFER_ADDR_BITS-1:0] x_addr,
    input  logic [31:0]                 x_din,
    output logic [BUFFER_ADDR_BITS-1:0] n_addr,
    input  logic [31:0]                 n_din,
    output logic [BUFFER_ADDR_BITS-1:0] y_addr,
    output logic                        y_wren,
    output logic [31:0]                 y_dout
);

    localparam int PROC_CNT_BITS = clog2(BUFFER_NUM_WORDS + 4);

    typedef logic [PROC_CNT_BITS-1:0]    cnt_t;
    typedef logic [BUFFER_ADDR_BITS-1:0] addr_t;

    localparam cnt_t CNT_READ_START  = cnt_t'(1);
    localparam cnt_t CNT_READ_LAST   = cnt_t'(BUFFER_NUM_WORDS);
    localparam cnt_t CNT_MASK        = cnt_t'(2);
    localparam cnt_t CNT_WRITE_START = cnt_t'(4);
    localparam cnt_t CNT_SUM_LAST    = cnt_t'(BUFFER_NUM_WORDS + 2);
    localparam cnt_t CNT_WRITE_LAST  = cnt_t'(BUFFER_NUM_WORDS + 3);

    cnt_t  proc_cnt_q, proc_cnt_d;
    addr_t addr_in_q, addr_in_d;
    addr_t addr_out_q, addr_out_d;
    logic  mask_q, mask_d;
    logic  c_top_q, c_top_d;
    word_t sum_prev_q;

    logic  mask_now;
    word_t add_b;
    logic  add_c_in;
    word_t add_s;
    logic  add_c_out;

    // Sequencing counter and address generators.
    always_comb begin
        proc_cnt_d = proc_cnt_q;
        if (proc_cnt_q == '0) begin
            if (ena) proc_cnt_d = CNT_READ_START;
        end else if (proc_cnt_q == CNT_WRITE_LAST) begin
            proc_cnt_d = '0;
        end else begin
            proc_cnt_d = proc_cnt_q + cnt_t'(1);
        end

        // Read address steps through 0..N-1 during cycles 1..N, else parks at 0.
        addr_in_d = '0;
        if (proc_cnt_q >= CNT_READ_START && proc_cnt_q < CNT_READ_LAST)
            addr_in_d = addr_in_q + addr_t'(1);

        // Write address steps through 0..N-1 during cycles 4..N+3.
        addr_out_d = '0;
        if (proc_cnt_q >= CNT_WRITE_START && proc_cnt_q < CNT_WRITE_LAST)
            addr_out_d = addr_out_q + addr_t'(1);
    end

    // The parity of x word 0 arrives in cycle 2 and is used straight away,
    // then held for the remaining words.
    assign mask_now = (proc_cnt_q == CNT_MASK) ? x_din[0] : mask_q;
    assign mask_d   = (proc_cnt_q == CNT_MASK) ? x_din[0] : mask_q;
    assign add_b    = n_din & {WORD_BITS{mask_now}};
    assign add_c_in = (proc_cnt_q == CNT_MASK) ? 1'b0 : add_c_out;

    // Carry out of the top word becomes bit 31 of the last result word.
    assign c_top_d  = (proc_cnt_q == CNT_SUM_LAST) ? add_c_out : c_top_q;

    adder32_wrapper u_adder (
        .clk   (clk),
        .a     (x_din),
        .b     (add_b),
        .c_in  (add_c_in),
        .s     (add_s),
        .c_out (add_c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            proc_cnt_q <= '0;
            addr_in_q  <= '0;
            addr_out_q <= '0;
            mask_q     <= 1'b0;
            c_top_q    <= 1'b0;
            sum_prev_q <= '0;
        end else begin
            proc_cnt_q <= proc_cnt_d;
            addr_in_q  <= addr_in_d;
            addr_out_q <= addr_out_d;
            mask_q     <= mask_d;
            c_top_q    <= c_top_d;
            sum_prev_q <= add_s;
        end
    end

    assign rdy    = (proc_cnt_q == '0);
    assign x_addr = addr_in_q;
    assign n_addr = addr_in_q;
    assign y_addr = addr_out_q;
    assign y_wren = (proc_cnt_q >= CNT_WRITE_START) && (proc_cnt_q <= CNT_WRITE_LAST);

    // Word i is the previous sum shifted right with the low bit of the next
    // sum (or the final carry for the top word) shifted in at bit 31.
    assign y_dout = (proc_cnt_q == CNT_WRITE_LAST) ? {c_top_q, sum_prev_q[31:1]}
                                                   : {add_s[0], sum_prev_q[31:1]};

endmodule

// File: tb/tb_modinv_helper_halve.sv
module tb_modinv_helper_halve;

    localparam int N = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        rdy;
    logic [3:0]  x_addr, n_addr, y_addr;
    logic [31:0] x_din, n_din, y_dout;
    logic        y_wren;

    logic [31:0] x_mem  [16];
    logic [31:0] n_mem  [16];
    logic [31:0] y_mem  [16];
    logic [31:0] x_init [16];
    logic [31:0] n_init [16];
    logic [31:0] y_exp  [N];
    logic        load_req;
    logic        alias_x;

    int errors = 0;
    int checks = 0;
    int done_k, nwr, first_wr, last_wr, addr_bad;

    always #5 clk = ~clk;

    modinv_helper_halve #(.BUFFER_NUM_WORDS(N), .BUFFER_ADDR_BITS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .rdy    (rdy),
        .x_addr (x_addr),
        .x_din  (x_din),
        .n_addr (n_addr),
        .n_din  (n_din),
        .y_addr (y_addr),
        .y_wren (y_wren),
        .y_dout (y_dout)
    );

    // Buffer model: registered reads, write port on y (optionally aliased onto x).
    always @(posedge clk) begin
        if (load_req) begin
            x_mem <= x_init;
            n_mem <= n_init;
            for (int i = 0; i < 16; i++) y_mem[i] <= 32'hDEADBEEF;
        end else begin
            x_din <= x_mem[x_addr];
            n_din <= n_mem[n_addr];
            if (y_wren) begin
                if (alias_x) x_mem[y_addr] <= y_dout;
                else         y_mem[y_addr] <= y_dout;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 16; i++) begin
            x_init[i] = 32'h0;
            n_init[i] = 32'h0;
        end
        for (int i = 0; i < N; i++) y_exp[i] = 32'h0;
    endtask

    task automatic set_n_p256();
        n_init[0] = 32'hFFFFFFFF; n_init[1] = 32'hFFFFFFFF; n_init[2] = 32'hFFFFFFFF;
        n_init[3] = 32'h0;        n_init[4] = 32'h0;        n_init[5] = 32'h0;
        n_init[6] = 32'h00000001; n_init[7] = 32'hFFFFFFFF; n_init[8] = 32'h0;
    endtask

    task automatic load(input logic alias_sel);
        @(negedge clk);
        alias_x  = alias_sel;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Start one operation; k counts cycles after the start cycle (cycle 0).
    task automatic run_op(input int pulse_at, input int rst_at);
        nwr = 0; first_wr = -1; last_wr = -1; addr_bad = 0; done_k = -1;
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        for (int k = 1; k < 100; k++) begin
            if (rdy) begin
                done_k = k;
                break;
            end
            if (x_addr !== n_addr) addr_bad++;
            if (y_wren) begin
                nwr++;
                if (first_wr < 0) first_wr = k;
                last_wr = k;
                if (int'(y_addr) != k - 4) addr_bad++;
            end
            ena = (k == pulse_at);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_mid_wren", {31'b0, y_wren}, 32'd0);
                check("rst_mid_rdy", {31'b0, rdy}, 32'd1);
                rst    = 1'b0;
                done_k = k + 1;
                break;
            end
            @(negedge clk);
        end
        ena = 1'b0;
    endtask

    task automatic check_run(input string tag);
        check({tag, "_done"},  32'(done_k),   32'd13);
        check({tag, "_nwr"},   32'(nwr),      32'd9);
        check({tag, "_first"}, 32'(first_wr), 32'd4);
        check({tag, "_last"},  32'(last_wr),  32'd12);
        check({tag, "_addr"},  32'(addr_bad), 32'd0);
    endtask

    task automatic check_y(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_y%0d", tag, i), alias_x ? x_mem[i] : y_mem[i], y_exp[i]);
    endtask

    initial begin
        int extra;
        int highs;
        int wr_cnt;
        logic rdy13, rdy14, rdy26;

        rst = 1'b1; ena = 1'b0; load_req = 1'b0; alias_x = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rdy",    {31'b0, rdy},    32'd1);
        check("reset_wren",   {31'b0, y_wren}, 32'd0);
        check("reset_x_addr", {28'b0, x_addr}, 32'd0);
        check("reset_n_addr", {28'b0, n_addr}, 32'd0);
        check("reset_y_addr", {28'b0, y_addr}, 32'd0);
        rst = 1'b0;

        // Even x passes through as x>>1.
        clear_vec(); x_init[0] = 32'd6; set_n_p256();
        y_exp[0] = 32'd3;
        load(1'b0); run_op(0, 0); check_run("even"); check_y("even");
        $display("txn even: done=%0d writes=%0d", done_k, nwr);

        // Odd small: (1+3)/2 = 2.
        clear_vec(); x_init[0] = 32'd1; n_init[0] = 32'd3;
        y_exp[0] = 32'd2;
        load(1'b0); run_op(0, 0); check_run("odd13"); check_y("odd13");
        $display("txn odd13: done=%0d writes=%0d", done_k, nwr);

        // Odd with carry into word 1: (5+0xFFFFFFFF)/2 = 0x80000002.
        clear_vec(); x_init[0] = 32'd5; n_init[0] = 32'hFFFFFFFF;
        y_exp[0] = 32'h80000002;
        load(1'b0); run_op(0, 0); check_y("odd5");
        $display("txn odd5: done=%0d writes=%0d", done_k, nwr);

        // Full carry: x = n = 2^288-1 -> y = 2^288-1.
        clear_vec();
        for (int i = 0; i < N; i++) begin
            x_init[i] = 32'hFFFFFFFF; n_init[i] = 32'hFFFFFFFF; y_exp[i] = 32'hFFFFFFFF;
        end
        load(1'b0); run_op(0, 0); check_run("full"); check_y("full");
        $display("txn full: done=%0d writes=%0d", done_k, nwr);

        // Cross-word shift: x = 2^32 -> y = 2^31.
        clear_vec(); x_init[1] = 32'd1; set_n_p256();
        y_exp[0] = 32'h80000000;
        load(1'b0); run_op(0, 0); check_y("xword");
        $display("txn xword: done=%0d writes=%0d", done_k, nwr);

        // In-place onto x: x = 2^288-3, n = P-256.
        clear_vec(); set_n_p256();
        x_init[0] = 32'hFFFFFFFD;
        for (int i = 1; i < N; i++) x_init[i] = 32'hFFFFFFFF;
        y_exp[0] = 32'hFFFFFFFE; y_exp[1] = 32'hFFFFFFFF; y_exp[2] = 32'h7FFFFFFF;
        y_exp[3] = 32'h0;        y_exp[4] = 32'h0;        y_exp[5] = 32'h80000000;
        y_exp[6] = 32'h80000000; y_exp[7] = 32'h7FFFFFFF; y_exp[8] = 32'h80000000;
        load(1'b1); run_op(0, 0); check_run("inplace"); check_y("inplace");
        $display("txn inplace: done=%0d writes=%0d", done_k, nwr);

        // ena pulsed mid-operation is ignored.
        clear_vec(); x_init[0] = 32'd1; n_init[0] = 32'd3; y_exp[0] = 32'd2;
        load(1'b0); run_op(5, 0); check_run("midena"); check_y("midena");
        $display("txn midena: done=%0d writes=%0d", done_k, nwr);

        // Reset in cycle 6: three writes, then idle with no more writes.
        load(1'b0); run_op(0, 6);
        check("rst_nwr", 32'(nwr), 32'd3);
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            if (y_wren || !rdy) extra++;
            @(negedge clk);
        end
        check("rst_quiet", 32'(extra), 32'd0);
        $display("txn reset_mid: writes=%0d after=%0d", nwr, extra);

        // ena held high: back-to-back, rdy high for one cycle between runs.
        highs = 0; wr_cnt = 0; rdy13 = 1'b0; rdy14 = 1'b1; rdy26 = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            if (rdy) highs++;
            if (y_wren) wr_cnt++;
            if (k == 13) rdy13 = rdy;
            if (k == 14) rdy14 = rdy;
            if (k == 26) begin
                rdy26 = rdy;
                ena   = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_rdy13",  {31'b0, rdy13}, 32'd1);
        check("b2b_rdy14",  {31'b0, rdy14}, 32'd0);
        check("b2b_rdy26",  {31'b0, rdy26}, 32'd1);
        check("b2b_highs",  32'(highs),     32'd3);
        check("b2b_writes", 32'(wr_cnt),    32'd18);
        $display("txn back_to_back: rdy_high=%0d writes=%0d", highs, wr_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
